// File: rtl/jtag_l2_mem_ctrl.sv
// JTAG bridge to single-port L2 SRAM controller with one-cycle responses.
// Optional power-up zero-fill of the whole SRAM when JTAG_L2_INIT_EN is defined.
module jtag_l2_mem_ctrl #(
    parameter int unsigned NUM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_n,
    input  logic                         req_i,
    output logic                         gnt_o,
    input  logic [31:0]                  addr_i,
    input  logic                         we_i,
    input  logic [3:0]                   be_i,
    input  logic [31:0]                  wdata_i,
    output logic                         r_valid_o,
    output logic [31:0]                  r_rdata_o,
    output logic                         r_err_o,
    output logic                         mem_csn_o,
    output logic                         mem_wen_o,
    output logic [$clog2(NUM_WORDS)-1:0] mem_addr_o,
    output logic [3:0]                   mem_be_o,
    output logic [31:0]                  mem_wdata_o,
    input  logic [31:0]                  mem_rdata_i,
    output logic                         busy_o
);

    localparam int unsigned AW       = $clog2(NUM_WORDS);
    localparam logic [32:0] SPAN     = 33'(NUM_WORDS) << 2;
    localparam logic [31:0] ERR_WORD = 32'hBADA_CCE5;

`ifdef JTAG_L2_INIT_EN
    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_RESP} state_t;
    localparam state_t ST_RESET = ST_INIT;
    localparam logic [AW-1:0] LAST_WORD = AW'(NUM_WORDS - 1);
    logic [AW-1:0] init_cnt_reg;
`else
    typedef enum logic {ST_IDLE, ST_RESP} state_t;
    localparam state_t ST_RESET = ST_IDLE;
`endif

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] offset;
    logic        in_range;
    logic        accept;
    logic        grant;
    logic        sel_sram;
    logic        resp_valid_reg;
    logic        resp_err_reg;
    logic        resp_read_reg;

    // Offset wraps for addresses below BASE_ADDR, so one unsigned compare covers both bounds.
    assign offset   = addr_i - BASE_ADDR;
    assign in_range = ({1'b0, offset} < SPAN) && (addr_i[1:0] == 2'b00);
    assign accept   = rst_n && ((state_reg == ST_IDLE) || (state_reg == ST_RESP));
    assign grant    = req_i && accept;
    assign sel_sram = grant && in_range && (!we_i || (be_i != 4'h0));
    assign gnt_o    = grant;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RESET;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
`ifdef JTAG_L2_INIT_EN
            ST_INIT: begin
                if (init_cnt_reg == LAST_WORD) begin
                    state_next = ST_IDLE;
                end
            end
`endif
            ST_IDLE: state_next = grant ? ST_RESP : ST_IDLE;
            ST_RESP: state_next = grant ? ST_RESP : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_csn_o   = 1'b1;
        mem_wen_o   = 1'b1;
        mem_addr_o  = '0;
        mem_be_o    = 4'h0;
        mem_wdata_o = 32'h0;
        if (sel_sram) begin
            mem_csn_o   = 1'b0;
            mem_wen_o   = ~we_i;
            mem_addr_o  = offset[AW+1:2];
            mem_be_o    = be_i;
            mem_wdata_o = wdata_i;
        end
`ifdef JTAG_L2_INIT_EN
        if (rst_n && (state_reg == ST_INIT)) begin
            mem_csn_o   = 1'b0;
            mem_wen_o   = 1'b0;
            mem_addr_o  = init_cnt_reg;
            mem_be_o    = 4'hF;
            mem_wdata_o = 32'h0;
        end
`endif
    end

`ifdef JTAG_L2_INIT_EN
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt_reg <= '0;
        end else if (state_reg == ST_INIT) begin
            init_cnt_reg <= init_cnt_reg + AW'(1);
        end
    end

    assign busy_o = (state_reg == ST_INIT);
`else
    assign busy_o = 1'b0;
`endif

    // Response pipeline: one stage, so ordering follows grant order by construction.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_read_reg  <= 1'b0;
        end else begin
            resp_valid_reg <= grant;
            resp_err_reg   <= grant && !in_range;
            resp_read_reg  <= grant && !we_i;
        end
    end

    assign r_valid_o = resp_valid_reg;
    assign r_err_o   = resp_err_reg;

    always_comb begin
        r_rdata_o = 32'h0;
        if (resp_valid_reg && resp_read_reg) begin
            r_rdata_o = resp_err_reg ? ERR_WORD : mem_rdata_i;
        end
    end

endmodule

// File: doc/jtag_l2_mem_ctrl.md
JTAG_L2_MEM_CTRL -- requirements
Module: jtag_l2_mem_ctrl

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 1024, meaning the number of 32-bit L2 words behind the controller (power of two, at least 4).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of word 0.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_i, input, 1 bit: request from the JTAG bus bridge.
REQ-006 SHALL have port gnt_o, output, 1 bit: request accepted this cycle.
REQ-007 SHALL have ports addr_i (input, 32 bits, byte address), we_i (input, 1 bit, 1=write), be_i (input, 4 bits, byte enables) and wdata_i (input, 32 bits, write data).
REQ-008 SHALL have ports r_valid_o (output, 1 bit, response valid), r_rdata_o (output, 32 bits, read data) and r_err_o (output, 1 bit, access error).
REQ-009 SHALL have ports mem_csn_o (output, 1 bit, SRAM chip select, active-low) and mem_wen_o (output, 1 bit, SRAM write enable, active-low).
REQ-010 SHALL have ports mem_addr_o (output, $clog2(NUM_WORDS) bits, word address), mem_be_o (output, 4 bits, byte enables), mem_wdata_o (output, 32 bits, write data) and mem_rdata_i (input, 32 bits, SRAM read data, valid one cycle after select).
REQ-011 SHALL have port busy_o, output, 1 bit: the controller is not accepting requests.

Function
REQ-012 The FSM SHALL have states INIT, IDLE and RESP.
REQ-013 In IDLE or RESP, gnt_o SHALL equal req_i combinationally, so back-to-back requests are granted every cycle.
REQ-014 A granted access SHALL be in range when BASE_ADDR <= addr_i < BASE_ADDR + 4*NUM_WORDS and addr_i[1:0] == 0.
REQ-015 For an in-range access, mem_addr_o SHALL be (addr_i - BASE_ADDR) >> 2 and mem_csn_o SHALL be 0 in the grant cycle.
REQ-016 For an in-range access, mem_wen_o SHALL be ~we_i, mem_be_o SHALL be be_i and mem_wdata_o SHALL be wdata_i.
REQ-017 An in-range write with be_i == 0 SHALL not select the SRAM and SHALL still produce a normal response.
REQ-018 Every grant SHALL produce exactly one response: r_valid_o high for exactly the cycle after the grant, with responses in grant order.
REQ-019 For an in-range read, r_rdata_o SHALL be mem_rdata_i; for a write, r_rdata_o SHALL be 0; r_err_o SHALL be 0 in both cases.
REQ-020 An out-of-range or misaligned access SHALL be granted without selecting the SRAM.
REQ-021 The response to such an access SHALL be r_err_o = 1, with r_rdata_o = 32'hBADACCE5 for a read and 0 for a write.
REQ-022 After a grant the FSM SHALL enter RESP; from RESP it SHALL return to IDLE, or stay in RESP if a new grant occurs in the same cycle.
REQ-023 Outside a grant cycle (or an INIT write), mem_csn_o SHALL be 1 and mem_wen_o SHALL be 1.
REQ-024 Whenever r_valid_o is 0, r_rdata_o and r_err_o SHALL be 0.
REQ-025 busy_o SHALL be 1 only in INIT.

Reset
REQ-026 While rst_n is 0: gnt_o=0, r_valid_o=0, r_rdata_o=0, r_err_o=0, mem_csn_o=1, mem_wen_o=1, mem_addr_o=0, mem_be_o=0, mem_wdata_o=0.
REQ-027 busy_o SHALL be 1 during reset if JTAG_L2_INIT_EN is defined, and 0 otherwise.
REQ-028 Asserting reset while a response is pending SHALL drop that response; no r_valid_o SHALL follow the reset.
REQ-029 After reset release, the FSM SHALL enter INIT if JTAG_L2_INIT_EN is defined, and IDLE otherwise.

Configuration
REQ-030 With macro JTAG_L2_INIT_EN defined, INIT SHALL write 32'h0 with mem_be_o=4'hF to word addresses 0 through NUM_WORDS-1, one word per cycle.
REQ-031 During INIT, gnt_o SHALL be 0 and busy_o SHALL be 1.
REQ-032 INIT SHALL move to IDLE in the cycle after the write to word NUM_WORDS-1, so busy_o is high for exactly NUM_WORDS cycles after reset release.
REQ-033 Without JTAG_L2_INIT_EN, INIT and its word counter SHALL not exist and busy_o SHALL be tied to 0.

Verification
REQ-034 Write 32'hABBAABBA to 32'h0 with be=4'hF, then read 32'h0 -> read response r_rdata_o=32'hABBAABBA, r_err_o=0; each r_valid_o is one cycle after its gnt_o.
REQ-035 Write 32'hFFFFFFFF to 32'h4, write 32'h00000012 with be=4'b0001, read 32'h4 -> 32'hFFFFFF12.
REQ-036 Read BASE_ADDR+4*NUM_WORDS, then read 32'h2 -> both responses have r_err_o=1 and r_rdata_o=32'hBADACCE5, and mem_csn_o stays 1.
REQ-037 Four back-to-back reads of addresses 0, 4, 8, 12 after writing 1, 2, 3, 4 -> gnt_o high for 4 consecutive cycles, then r_valid_o high for 4 consecutive cycles returning 1, 2, 3, 4 in order.
REQ-038 With JTAG_L2_INIT_EN: preload an SRAM model with 32'hDEADBEEF and release reset -> busy_o high for NUM_WORDS cycles, gnt_o=0 throughout, and a later read of 32'h10 returns 0.
REQ-039 Assert rst_n=0 in the cycle after a read grant -> r_valid_o never rises for that read, and outputs match the reset values of REQ-026.
